// File: rtl/shout_listen.sv
// shout_listen: locks onto an asynchronous square-wave tone and reports its period.
//
// Ports:
//   clk_in       - sole clock, all logic on the rising edge
//   rst_n        - asynchronous active-low reset
//   shout_in     - asynchronous square-wave tone input
//   locked       - high while the tone is locked
//   period_out   - last accepted period in clk_in cycles (CNT_W bits)
//   period_valid - one-cycle pulse when period_out updates
//   lost         - one-cycle pulse when lock is dropped
module shout_listen #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_PERIOD = 8,
    parameter int unsigned MAX_PERIOD = 1000,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             shout_in,
    output logic             locked,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             lost
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] TOL_P   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [MW-1:0]    LAST_M  = MW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync2_q, sync3_q;
    logic edge_q, edge_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [1:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             period_valid_q, period_valid_d;
    logic             lost_q, lost_d;

    logic             in_range;
    logic             near;
    logic             timeout;
    logic [CNT_W-1:0] ref_period;
    logic [CNT_W-1:0] diff;

    // Synchroniser plus a registered rising-edge pulse.
    always_comb begin
        edge_d = sync2_q & ~sync3_q;
    end

    // cnt_q is loaded with 1 on an edge, so at the next edge it equals the period.
    // While locked, a period is judged against the locked period rather than the
    // previous one, so a single outlier does not poison the following comparison.
    always_comb begin
        ref_period = (state_q == LOCKED) ? period_out_q : prev_q;
        diff       = (cnt_q >= ref_period) ? (cnt_q - ref_period) : (ref_period - cnt_q);
        in_range   = (cnt_q >= MIN_P) && (cnt_q <= MAX_P);
        near       = (diff <= TOL_P);
        timeout    = (cnt_q > MAX_P);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        prev_d         = prev_q;
        period_out_d   = period_out_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        locked_d       = locked_q;
        period_valid_d = 1'b0;
        lost_d         = 1'b0;

        if (edge_q) begin
            cnt_d = CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                locked_d = 1'b0;
                if (edge_q) begin
                    state_d     = ACQUIRE;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            end

            ACQUIRE: begin
                if (edge_q) begin
                    prev_d = cnt_q;
                    if (in_range && ((match_cnt_q == '0) || near)) begin
                        if (match_cnt_q == LAST_M) begin
                            state_d        = LOCKED;
                            locked_d       = 1'b1;
                            period_out_d   = cnt_q;
                            period_valid_d = 1'b1;
                            miss_cnt_d     = '0;
                            match_cnt_d    = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end

            LOCKED: begin
                if (edge_q) begin
                    prev_d = cnt_q;
                    if (in_range && near) begin
                        period_out_d   = cnt_q;
                        period_valid_d = 1'b1;
                        miss_cnt_d     = '0;
                    end else if (miss_cnt_q == 2'd1) begin
                        state_d     = ACQUIRE;
                        locked_d    = 1'b0;
                        lost_d      = 1'b1;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    locked_d    = 1'b0;
                    lost_d      = 1'b1;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            end

            default: begin
                state_d  = IDLE;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            edge_q         <= 1'b0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            prev_q         <= '0;
            period_out_q   <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            locked_q       <= 1'b0;
            period_valid_q <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            sync1_q        <= shout_in;
            sync2_q        <= sync1_q;
            sync3_q        <= sync2_q;
            edge_q         <= edge_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            period_out_q   <= period_out_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            locked_q       <= locked_d;
            period_valid_q <= period_valid_d;
            lost_q         <= lost_d;
        end
    end

    assign locked       = locked_q;
    assign period_out   = period_out_q;
    assign period_valid = period_valid_q;
    assign lost         = lost_q;

endmodule

// File: doc/shout_listen.md
SHOUT_LISTEN -- requirements
Module: shout_listen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period counter and period_out.
REQ-002 SHALL have parameter MIN_PERIOD, default 8, smallest accepted period in clk_in cycles.
REQ-003 SHALL have parameter MAX_PERIOD, default 1000, largest accepted period; also the edge timeout.
REQ-004 SHALL have parameter TOL, default 2, maximum |period - previous period| counted as a match.
REQ-005 SHALL have parameter LOCK_COUNT, default 4, consecutive matching periods required to lock.
REQ-006 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port shout_in  input  1  asynchronous square-wave tone, the receive end of shout_out.
REQ-009 SHALL have port locked  output  1  high while the tone is locked.
REQ-010 SHALL have port period_out  output  CNT_W  last accepted period in clk_in cycles.
REQ-011 SHALL have port period_valid  output  1  one-cycle pulse when period_out updates.
REQ-012 SHALL have port lost  output  1  one-cycle pulse when lock is dropped.

Function
REQ-013 SHALL synchronise shout_in through 2 flops, then detect rising edges with a third registered stage.
REQ-014 SHALL measure period as clk_in cycles between consecutive detected rising edges, so a steady wave of period P gives P.
REQ-015 SHALL saturate the period counter at 2^CNT_W-1 and never wrap.
REQ-016 SHALL implement FSM states IDLE, ACQUIRE and LOCKED; reset state is IDLE.
REQ-017 IDLE: on the first detected edge, SHALL clear the counter, clear match_cnt and go to ACQUIRE; no period is measured.
REQ-018 ACQUIRE: on each edge, if MIN_PERIOD <= period <= MAX_PERIOD and |period-prev| <= TOL, SHALL increment match_cnt; otherwise match_cnt SHALL be cleared. The first in-range period SHALL count as a match.
REQ-019 ACQUIRE: when match_cnt reaches LOCK_COUNT, SHALL enter LOCKED, set locked=1, load period_out and pulse period_valid in the same cycle.
REQ-020 prev SHALL be updated with every measured period, in range or not.
REQ-021 LOCKED: on each matching edge, SHALL load period_out, pulse period_valid and clear miss_cnt.
REQ-022 LOCKED: on a non-matching edge, SHALL increment miss_cnt and leave period_out unchanged. At miss_cnt == 2, SHALL go to ACQUIRE with locked=0, pulse lost and clear match_cnt.
REQ-023 In ACQUIRE or LOCKED, if the counter exceeds MAX_PERIOD with no edge, SHALL go to IDLE. lost SHALL pulse only if leaving LOCKED; locked SHALL be 0.
REQ-024 If timeout and an edge fall in the same cycle, the edge SHALL win.
REQ-025 period_valid and locked SHALL assert no earlier than 3 cycles after shout_in is first sampled high at the edge that completes lock.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_n low SHALL immediately force locked=0, period_out=0, period_valid=0, lost=0, state IDLE, and clear all counters and synchroniser flops.
REQ-028 Reset asserted mid-LOCKED SHALL NOT produce a lost pulse; after release, the block SHALL reacquire from IDLE.

Verification
REQ-029 Reset: hold rst_n=0, toggle shout_in -> all outputs 0; release -> state IDLE.
REQ-030 Steady period 100 -> locked=1 and period_out=100 at the 5th rising edge; period_valid pulses every 100 cycles thereafter.
REQ-031 Jitter alternating 99/101 -> locks (diff 2 <= TOL); alternating 96/104 -> never locks.
REQ-032 Locked at 100, then one period of 150, then 100 -> stays locked. Two consecutive 150s -> lost pulse, locked=0, ACQUIRE.
REQ-033 Locked, shout_in held low -> lost pulse and IDLE 1001 cycles after the last edge. Period 5 (< MIN_PERIOD) -> locked never asserts.
REQ-034 rst_n pulsed low while locked -> outputs zero asynchronously, no lost pulse; relock at 100 on the 5th edge after release.
